color_palette_pipe: RTL

COLOR_PALETTE_PIPE -- requirements
Module: color_palette_pipe

---
 rtl/palette_pkg.sv | 23 ++
 rtl/palette_rot_ctrl.sv | 38 +++
 rtl/color_palette_pipe.sv | 134 +++++++++++++
 3 files changed

// File: rtl/palette_pkg.sv
// rtl/palette_pkg.sv - shared palette mode and band colour definitions
package palette_pkg;

  // Palette selection held in the mode register; RSVD renders as GRAY.
  typedef enum logic [1:0] {
    GRAY = 2'd0,
    BAND = 2'd1,
    GRAD = 2'd2,
    RSVD = 2'd3
  } palette_mode_t;

  // Band colour chosen by the two low index bits in BAND mode.
  localparam logic [1:0] BAND_RED   = 2'd0;
  localparam logic [1:0] BAND_GREEN = 2'd1;
  localparam logic [1:0] BAND_BLUE  = 2'd2;
  localparam logic [1:0] BAND_WHITE = 2'd3;

  // Only the banded and gradient palettes follow the rotating offset.
  function automatic logic mode_rotates(input palette_mode_t m);
    return (m == BAND) || (m == GRAD);
  endfunction

endpackage

// File: rtl/palette_rot_ctrl.sv
// rtl/palette_rot_ctrl.sv - palette mode register and per-frame rotation offset
module palette_rot_ctrl
  import palette_pkg::*;
#(
  parameter int ITER_W   = 8,
  parameter int ROT_STEP = 1
) (
  input  logic              clk,
  input  logic              rst,
  input  logic [1:0]        mode,
  input  logic              mode_wr,
  input  logic              frame_tick,
  output palette_mode_t     mode_q,
  output logic [ITER_W-1:0] offset
);

  // Step truncated to the offset width so the counter wraps modulo 2^ITER_W.
  localparam logic [ITER_W-1:0] STEP = ITER_W'(ROT_STEP);

  // Mode register: loaded on the write strobe, independent of frame_tick.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      mode_q <= GRAY;
    end else if (mode_wr) begin
      mode_q <= palette_mode_t'(mode);
    end
  end

  // Rotation offset: advances once per frame, natural wrap at the top.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      offset <= '0;
    end else if (frame_tick) begin
      offset <= offset + STEP;
    end
  end

endmodule

// File: rtl/color_palette_pipe.sv
// rtl/color_palette_pipe.sv - two-stage iteration-count to RGB palette pipeline
module color_palette_pipe
  import palette_pkg::*;
#(
  parameter int ITER_W   = 8,
  parameter int COLOR_W  = 8,
  parameter int ROT_STEP = 1
) (
  input  logic                 clk,
  input  logic                 rst,
  input  logic                 in_valid,
  output logic                 in_ready,
  input  logic [ITER_W-1:0]    in_iter,
  input  logic                 in_inset,
  input  logic [1:0]           mode,
  input  logic                 mode_wr,
  input  logic                 frame_tick,
  output logic                 out_valid,
  input  logic                 out_ready,
  output logic [3*COLOR_W-1:0] out_rgb
);

  palette_mode_t     mode_q;
  logic [ITER_W-1:0] offset;

  palette_rot_ctrl #(
    .ITER_W   (ITER_W),
    .ROT_STEP (ROT_STEP)
  ) u_rot (
    .clk        (clk),
    .rst        (rst),
    .mode       (mode),
    .mode_wr    (mode_wr),
    .frame_tick (frame_tick),
    .mode_q     (mode_q),
    .offset     (offset)
  );

  // Stage 1: palette index, inset flag and the mode the sample was accepted under.
  logic              s1_valid;
  logic              s1_inset;
  logic [ITER_W-1:0] s1_idx;
  palette_mode_t     s1_mode;

  // Stage 2: final colour, driven straight to the output.
  logic                 s2_valid;
  logic [3*COLOR_W-1:0] s2_rgb;

  logic              s1_adv;
  logic [ITER_W-1:0] in_idx;

  // Stage 1 moves forward whenever stage 2 is empty or being drained.
  assign s1_adv   = !s2_valid || out_ready;
  assign in_ready = !s1_valid || s1_adv;

  // The offset is folded in at acceptance so a later frame_tick cannot
  // change the colour of a sample already in flight.
  assign in_idx = mode_rotates(mode_q) ? (in_iter + offset) : in_iter;

  // Stage 1 register: load on every ready cycle, payload only with a sample.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      s1_valid <= 1'b0;
      s1_inset <= 1'b0;
      s1_idx   <= '0;
      s1_mode  <= GRAY;
    end else if (in_ready) begin
      s1_valid <= in_valid;
      if (in_valid) begin
        s1_inset <= in_inset;
        s1_idx   <= in_idx;
        s1_mode  <= mode_q;
      end
    end
  end

  // Grey level: top COLOR_W index bits, or the index left-aligned and
  // zero-filled when the iteration count is narrower than a channel.
  logic [COLOR_W-1:0] g;
  logic [COLOR_W-1:0] g_shl;
  logic [COLOR_W-1:0] cmax;
  logic [COLOR_W-1:0] czero;

  generate
    if (ITER_W >= COLOR_W) begin : g_trunc
      assign g = s1_idx[ITER_W-1 -: COLOR_W];
    end else begin : g_pad
      assign g = {s1_idx, {(COLOR_W-ITER_W){1'b0}}};
    end
  endgenerate

  assign g_shl = g << 1;
  assign cmax  = '1;
  assign czero = '0;

  logic [3*COLOR_W-1:0] rgb_next;

  // Colour lookup for the stage 1 sample; inset points are always black.
  always_comb begin
    rgb_next = '0;
    if (!s1_inset) begin
      case (s1_mode)
        BAND: begin
          case (s1_idx[1:0])
            BAND_RED:   rgb_next = {cmax,  czero, czero};
            BAND_GREEN: rgb_next = {czero, cmax,  czero};
            BAND_BLUE:  rgb_next = {czero, czero, cmax};
            BAND_WHITE: rgb_next = {cmax,  cmax,  cmax};
            default:    rgb_next = '0;
          endcase
        end
        GRAD:    rgb_next = {g, g_shl, ~g};
        default: rgb_next = {g, g, g};
      endcase
    end
  end

  // Stage 2 register: holds while stalled so out_rgb stays stable.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      s2_valid <= 1'b0;
      s2_rgb   <= '0;
    end else if (s1_adv) begin
      s2_valid <= s1_valid;
      if (s1_valid) begin
        s2_rgb <= rgb_next;
      end
    end
  end

  assign out_valid = s2_valid;
  assign out_rgb   = s2_rgb;

endmodule
